// File: rtl/mem_cycle_ctl.sv
// Main-memory cycle controller: runs one read or write bus cycle at a time,
// buffers read data for the memory data register and flags NXM/parity errors.
module mem_cycle_ctl #(
  parameter int unsigned ADDR_W    = 22,
  parameter int unsigned TIMEOUT   = 255,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic [ADDR_W-1:0] vma,
  input  logic [31:0]       md,
  input  logic [31:0]       ob,
  input  logic              destmdr,
  input  logic              err_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic [3:0]        mem_rpar,
  output logic [31:0]       mds,
  output logic              loadmd,
  output logic              memrq,
  output logic              mem_wait,
  output logic              mem_busy,
  output logic              mem_nxm,
  output logic              mem_parerr
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StReq   = 2'd1;
  localparam logic [1:0] StRdone = 2'd2;

  localparam logic [7:0] TimeoutInit = 8'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic              nxm_q, nxm_d;
  logic              parerr_q, parerr_d;
  logic              nxm_set, par_set, par_bad;

  // Odd parity per byte: each byte together with its parity bit must hold an odd count of ones.
  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (^{mem_rdata[8*i +: 8], mem_rpar[i]} == 1'b0) par_bad = 1'b1;
    end
  end

  // Cycle sequencing: latch request, wait for ack or timeout, then complete.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    nxm_set = 1'b0;
    par_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_rd || start_wr) begin
          addr_d  = vma;
          wdata_d = md;
          we_d    = start_wr;  // write wins on a simultaneous start
          cnt_d   = TimeoutInit;
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d = cnt_q - 8'd1;
        // Ack is tested first so an ack on the final counted cycle is not an NXM.
        if (mem_ack) begin
          rbuf_d  = mem_rdata;
          par_set = PARITY_EN && !we_q && par_bad;
          state_d = we_q ? StIdle : StRdone;
        end else if (cnt_q == 8'd1) begin
          nxm_set = 1'b1;
          rbuf_d  = 32'hFFFF_FFFF;
          state_d = we_q ? StIdle : StRdone;
        end
      end
      StRdone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A same-cycle set beats err_clr.
    nxm_d    = nxm_set | (nxm_q & ~err_clr);
    parerr_d = par_set | (parerr_q & ~err_clr);
  end

  // State registers; reset abandons any cycle in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rbuf_q   <= 32'd0;
      nxm_q    <= 1'b0;
      parerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
      nxm_q    <= nxm_d;
      parerr_q <= parerr_d;
    end
  end

  // Output decode.
  always_comb begin
    mem_req    = (state_q == StReq);
    mem_we     = we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    mds        = destmdr ? ob : rbuf_q;
    loadmd     = (state_q == StRdone);
    memrq      = (state_q == StRdone);
    mem_busy   = (state_q != StIdle);
    mem_wait   = (start_rd | start_wr) & mem_busy;
    mem_nxm    = nxm_q;
    mem_parerr = parerr_q;
  end

endmodule

// File: tb/tb_mem_cycle_ctl.sv
// Bench for mem_cycle_ctl: directed bus transactions, a cycle-level reference
// model compared every cycle, plus literal expectations at key points.
module tb_mem_cycle_ctl;

  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start_rd = 1'b0, start_wr = 1'b0;
  logic [21:0] vma = '0;
  logic [31:0] md = '0, ob = '0;
  logic        destmdr = 1'b0, err_clr = 1'b0;
  logic        mem_req, mem_we;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  mem_rpar = '0;
  logic [31:0] mds;
  logic        loadmd, memrq, mem_wait, mem_busy, mem_nxm, mem_parerr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_cycle_ctl #(.ADDR_W(22), .TIMEOUT(TIMEOUT), .PARITY_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start_rd(start_rd), .start_wr(start_wr),
    .vma(vma), .md(md), .ob(ob), .destmdr(destmdr), .err_clr(err_clr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rpar(mem_rpar), .mds(mds),
    .loadmd(loadmd), .memrq(memrq), .mem_wait(mem_wait), .mem_busy(mem_busy),
    .mem_nxm(mem_nxm), .mem_parerr(mem_parerr)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // True when every byte plus its parity bit holds an odd number of ones.
  function automatic bit parity_good(logic [31:0] d, logic [3:0] p);
    for (int i = 0; i < 4; i++) begin
      if (($countones(d[8*i +: 8]) + int'(p[i])) % 2 == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model: a transaction is either requesting (counting elapsed cycles)
  // or completing a read; nothing else is in flight.
  logic        m_req = 1'b0, m_rdone = 1'b0, m_we = 1'b0, m_nxm = 1'b0, m_par = 1'b0;
  logic [21:0] m_addr = '0;
  logic [31:0] m_wdata = '0, m_rbuf = '0;
  int          m_elapsed = 0;
  logic        n_req, n_rdone, n_we, n_nxm, n_par, hit_nxm, hit_par;
  logic [21:0] n_addr;
  logic [31:0] n_wdata, n_rbuf;
  int          n_elapsed;

  always_comb begin
    n_req = m_req; n_rdone = 1'b0; n_we = m_we; n_addr = m_addr;
    n_wdata = m_wdata; n_rbuf = m_rbuf; n_elapsed = m_elapsed;
    hit_nxm = 1'b0; hit_par = 1'b0;
    if (m_req) begin
      n_elapsed = m_elapsed + 1;
      if (mem_ack) begin
        n_rbuf  = mem_rdata;
        hit_par = !m_we && !parity_good(mem_rdata, mem_rpar);
        n_req   = 1'b0;
        n_rdone = !m_we;
      end else if (n_elapsed == int'(TIMEOUT)) begin
        hit_nxm = 1'b1;
        n_rbuf  = 32'hFFFF_FFFF;
        n_req   = 1'b0;
        n_rdone = !m_we;
      end
    end else if (!m_rdone && (start_rd || start_wr)) begin
      n_req = 1'b1; n_we = start_wr; n_addr = vma; n_wdata = md; n_elapsed = 0;
    end
    n_nxm = hit_nxm || (m_nxm && !err_clr);
    n_par = hit_par || (m_par && !err_clr);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_req <= 1'b0; m_rdone <= 1'b0; m_we <= 1'b0; m_nxm <= 1'b0; m_par <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rbuf <= '0; m_elapsed <= 0;
    end else begin
      m_req <= n_req; m_rdone <= n_rdone; m_we <= n_we; m_nxm <= n_nxm; m_par <= n_par;
      m_addr <= n_addr; m_wdata <= n_wdata; m_rbuf <= n_rbuf; m_elapsed <= n_elapsed;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("mem_req", 32'(mem_req), 32'(m_req));
    chk("mem_busy", 32'(mem_busy), 32'(m_req | m_rdone));
    chk("loadmd", 32'(loadmd), 32'(m_rdone));
    chk("memrq", 32'(memrq), 32'(m_rdone));
    chk("mem_wait", 32'(mem_wait), 32'((start_rd | start_wr) & (m_req | m_rdone)));
    chk("mds", mds, destmdr ? ob : m_rbuf);
    chk("mem_nxm", 32'(mem_nxm), 32'(m_nxm));
    chk("mem_parerr", 32'(mem_parerr), 32'(m_par));
    if (m_req) begin
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_wdata", mem_wdata, m_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cycle(input logic rd, input logic wr, input logic [21:0] a,
                             input logic [31:0] d);
    start_rd = rd; start_wr = wr; vma = a; md = d;
    tick();
    start_rd = 1'b0; start_wr = 1'b0;
  endtask

  task automatic ack(input logic [31:0] d, input logic [3:0] p);
    mem_ack = 1'b1; mem_rdata = d; mem_rpar = p;
    tick();
    mem_ack = 1'b0; mem_rdata = '0; mem_rpar = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    #3;
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_busy", 32'(mem_busy), 32'd0);
    chk("reset mds", mds, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Read with ack on the third request cycle.
    start_cycle(1'b1, 1'b0, 22'h000100, 32'd0);
    chk("rd mem_req", 32'(mem_req), 32'd1);
    chk("rd mem_addr", 32'(mem_addr), 32'h100);
    chk("rd mem_we", 32'(mem_we), 32'd0);
    tick(); tick();
    ack(32'h1234_5678, 4'b1011);
    chk("rd loadmd", 32'(loadmd), 32'd1);
    chk("rd memrq", 32'(memrq), 32'd1);
    chk("rd mds", mds, 32'h1234_5678);
    chk("rd parerr", 32'(mem_parerr), 32'd0);
    tick();
    chk("rd done busy", 32'(mem_busy), 32'd0);
    chk("rd done loadmd", 32'(loadmd), 32'd0);

    // Write; simultaneous start_rd must lose to start_wr.
    start_cycle(1'b1, 1'b1, 22'h3ABCDE, 32'hDEAD_BEEF);
    chk("wr mem_we", 32'(mem_we), 32'd1);
    chk("wr wdata", mem_wdata, 32'hDEAD_BEEF);
    tick(); tick();
    chk("wr held req", 32'(mem_req), 32'd1);
    chk("wr held wdata", mem_wdata, 32'hDEAD_BEEF);
    ack(32'd0, 4'hF);
    chk("wr busy clear", 32'(mem_busy), 32'd0);
    chk("wr no loadmd", 32'(loadmd), 32'd0);
    tick();

    // No ack: NXM after TIMEOUT request cycles, then err_clr.
    start_cycle(1'b1, 1'b0, 22'h2AAAAA, 32'd0);
    repeat (TIMEOUT - 1) tick();
    chk("nxm still req", 32'(mem_req), 32'd1);
    chk("nxm not yet", 32'(mem_nxm), 32'd0);
    tick();
    chk("nxm set", 32'(mem_nxm), 32'd1);
    chk("nxm loadmd", 32'(loadmd), 32'd1);
    chk("nxm mds", mds, 32'hFFFF_FFFF);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("nxm cleared", 32'(mem_nxm), 32'd0);

    // Ack on the last counted cycle with bad parity: parerr, no NXM.
    start_cycle(1'b1, 1'b0, 22'h000004, 32'd0);
    repeat (TIMEOUT - 1) tick();
    ack(32'd0, 4'b0000);
    chk("edge nxm", 32'(mem_nxm), 32'd0);
    chk("edge parerr", 32'(mem_parerr), 32'd1);
    chk("edge mds", mds, 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("parerr cleared", 32'(mem_parerr), 32'd0);

    // A parity set coinciding with err_clr must win.
    start_cycle(1'b1, 1'b0, 22'h000008, 32'd0);
    err_clr = 1'b1;
    ack(32'h0000_0001, 4'b1111);
    err_clr = 1'b0;
    chk("set beats clr", 32'(mem_parerr), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Start while busy stalls and is ignored; destmdr overrides mds.
    start_cycle(1'b1, 1'b0, 22'h000200, 32'd0);
    start_rd = 1'b1; vma = 22'h0000FF;
    #1;
    chk("wait busy", 32'(mem_wait), 32'd1);
    tick();
    chk("no relatch", 32'(mem_addr), 32'h200);
    ack(32'hCAFE_F00D, 4'b1010);
    chk("wait rdone", 32'(mem_wait), 32'd1);
    destmdr = 1'b1; ob = 32'h0F0F_0F0F;
    #1;
    chk("destmdr mds", mds, 32'h0F0F_0F0F);
    chk("destmdr loadmd", 32'(loadmd), 32'd1);
    start_rd = 1'b0; destmdr = 1'b0;
    #1;
    chk("rbuf mds", mds, 32'hCAFE_F00D);
    tick();

    // Reset mid-request drops mem_req at once and completes nothing.
    start_cycle(1'b1, 1'b0, 22'h000300, 32'd0);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst busy", 32'(mem_busy), 32'd0);
    tick(); tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick();
    chk("post rst loadmd", 32'(loadmd), 32'd0);
    chk("post rst busy", 32'(mem_busy), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
